// File: rtl/telemeter_mem_arbiter.sv
// -----------------------------------------------------------------------------
// telemeter_mem_arbiter
//
// Shares the single port of the telemeter sample RAM (32-bit words, DEPTH deep,
// 1-cycle read latency) between two requesters:
//   * the radar sweep capture stream, which writes {angle, distance} samples
//     into a wrapping frame buffer, and
//   * the CPU Avalon-MM slave path, which reads and writes arbitrary words.
// It also keeps the capture write pointer and the sweep frame count that
// software polls.
//
// Handshakes:
//   Capture: a sample is transferred on every cycle where cap_valid=1 and
//   cap_ready=1. cap_ready is only ever high when cap_valid is high, so the
//   source must hold cap_valid/cap_data/cap_sof stable until it sees
//   cap_ready. cap_sof qualifies the sample and has no effect until the
//   sample is accepted.
//   CPU: a request (cpu_read or cpu_write) is accepted on the cycle where
//   cpu_waitrequest=0. The master must hold the request while
//   cpu_waitrequest=1. An accepted read returns cpu_readdatavalid=1 exactly
//   one cycle later. Writes complete in their accept cycle with no response.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   cap_valid/data/sof    capture sample in
//   cap_ready             capture sample accepted this cycle
//   freeze                stalls capture so software reads a stable frame
//   cpu_*                 Avalon-MM slave (address, read, write, byteenable,
//                         writedata, waitrequest, readdata, readdatavalid)
//   wr_ptr                next capture address
//   frame_count           number of SOF samples written (wraps at 16 bits)
//   mem_*                 RAM port (address, byteenable, chipselect, write,
//                         writedata, readdata)
// -----------------------------------------------------------------------------
module telemeter_mem_arbiter #(
  parameter int DEPTH  = 40000,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cap_valid,
  input  logic [31:0]       cap_data,
  input  logic              cap_sof,
  output logic              cap_ready,
  input  logic              freeze,

  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [3:0]        cpu_byteenable,
  input  logic [31:0]       cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid,

  output logic [ADDR_W-1:0] wr_ptr,
  output logic [15:0]       frame_count,

  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              r_last;        // 0: capture won last grant, 1: CPU won last
  logic              r_rd_pend;     // a granted CPU read returns data this cycle
  logic              r_rd_oor;      // that read was out of range, return 0
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [15:0]       r_frame_count;

  // ---------------------------------------------------------------------------
  // Requests and grant
  // ---------------------------------------------------------------------------
  logic              w_cpu_req_raw;
  logic              w_cap_req;
  logic              w_cpu_req;
  logic              w_grant_cap;
  logic              w_grant_cpu;
  logic              w_cpu_in_range;
  logic              w_cpu_rd_accept;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [15:0]       w_frame_count_nxt;
  logic              w_last_nxt;

  assign w_cpu_req_raw = cpu_read | cpu_write;

  // No grant is issued while reset is held, so every output sits at its
  // reset value and waitrequest simply mirrors the CPU request.
  assign w_cap_req = cap_valid & ~freeze & ~reset;
  assign w_cpu_req = w_cpu_req_raw & ~reset;

  // Round-robin between two requesters: under contention the side that did
  // not win last time goes next; a lone requester always wins.
  assign w_grant_cap = w_cap_req & (~w_cpu_req | r_last);
  assign w_grant_cpu = w_cpu_req & ~w_grant_cap;

  assign w_cpu_in_range  = ({1'b0, cpu_address} < DEPTH_EXT);
  // cpu_write wins over cpu_read when both are asserted.
  assign w_cpu_rd_accept = w_grant_cpu & cpu_read & ~cpu_write;

  // ---------------------------------------------------------------------------
  // Handshake outputs
  // ---------------------------------------------------------------------------
  assign cap_ready         = w_grant_cap;
  assign cpu_waitrequest   = w_cpu_req_raw & ~w_grant_cpu;
  assign cpu_readdatavalid = r_rd_pend;
  assign cpu_readdata      = (r_rd_pend && !r_rd_oor) ? mem_readdata : 32'h0;

  assign wr_ptr      = r_wr_ptr;
  assign frame_count = r_frame_count;

  // ---------------------------------------------------------------------------
  // RAM port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_address    = '0;
    mem_byteenable = 4'h0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = 32'h0;
    if (w_grant_cap) begin
      // An SOF sample always starts the frame buffer at word 0.
      mem_address    = cap_sof ? '0 : r_wr_ptr;
      mem_byteenable = 4'hF;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_writedata  = cap_data;
    end else if (w_grant_cpu) begin
      mem_address    = cpu_address;
      mem_byteenable = cpu_byteenable;
      // Out-of-range accesses never reach the RAM: writes are dropped and
      // reads are answered with 0 by the return path.
      mem_chipselect = w_cpu_in_range;
      mem_write      = cpu_write;
      mem_writedata  = cpu_writedata;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture pointer, frame counter and arbitration history
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wr_ptr_nxt      = r_wr_ptr;
    w_frame_count_nxt = r_frame_count;
    w_last_nxt        = r_last;
    if (w_grant_cap) begin
      w_last_nxt = 1'b0;
      if (cap_sof) begin
        // The SOF sample occupies word 0, so the next sample goes to word 1.
        w_wr_ptr_nxt      = ADDR_W'(1);
        w_frame_count_nxt = r_frame_count + 16'd1;
      end else if (r_wr_ptr == LAST_ADDR) begin
        w_wr_ptr_nxt = '0;
      end else begin
        w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
      end
    end else if (w_grant_cpu) begin
      w_last_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // last=1 so capture wins the first contention after reset.
      r_last        <= 1'b1;
      r_rd_pend     <= 1'b0;
      r_rd_oor      <= 1'b0;
      r_wr_ptr      <= '0;
      r_frame_count <= 16'h0;
    end else begin
      r_last        <= w_last_nxt;
      r_rd_pend     <= w_cpu_rd_accept;
      r_rd_oor      <= w_cpu_rd_accept & ~w_cpu_in_range;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_frame_count <= w_frame_count_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_one_grant : assert property (@(posedge clk) disable iff (reset)
    !(w_grant_cap && w_grant_cpu));

  a_ptr_in_range : assert property (@(posedge clk) disable iff (reset)
    ({1'b0, r_wr_ptr} < DEPTH_EXT) || (DEPTH == 1));

endmodule
